alu_share_ctrl: RTL and testbench

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

---
 rtl/alu_share_ctrl_pkg.sv | 25 ++
 rtl/alu_share_ctrl_core.sv | 38 +++
 rtl/alu_share_ctrl.sv | 106 ++++++++++
 tb/tb_alu_share_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the two-requester shared-ALU controller:
// op codes, FSM states and condition-code bit positions.
package alu_share_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // cc is packed as {ZF,SF,OF}
  localparam int unsigned CC_ZF = 2;
  localparam int unsigned CC_SF = 1;
  localparam int unsigned CC_OF = 0;

  localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/alu_share_ctrl_core.sv
// Combinational 64-bit ALU: add/sub share one adder (sub = a + ~b + 1),
// plus bitwise and/xor and the ZF/SF/OF flags.
module alu_core
  import alu_share_ctrl_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic [63:0] result,
  output logic        zf,
  output logic        sf,
  output logic        of
);

  logic        w_sub;
  logic        w_arith;
  logic [63:0] w_b_eff;
  logic [63:0] w_sum;

  assign w_sub   = (op_e'(op) == OP_SUB);
  assign w_arith = (op_e'(op) == OP_ADD) || w_sub;
  assign w_b_eff = w_sub ? ~b : b;
  assign w_sum   = a + w_b_eff + {63'd0, w_sub};

  always_comb begin
    case (op_e'(op))
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      default: result = w_sum;
    endcase
  end

  assign zf = (result == '0);
  assign sf = result[63];
  // With b already inverted for sub, one same-sign rule covers both add and sub.
  assign of = w_arith && (a[63] == w_b_eff[63]) && (w_sum[63] != a[63]);

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter sharing one alu_core between two requesters.
// IDLE grants and latches operands, EXEC registers the result, RESP strobes valid.
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [63:0] a0,
  input  logic [63:0] b0,
  input  logic [63:0] a1,
  input  logic [63:0] b1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        valid,
  output logic        res_id,
  output logic [63:0] result,
  output logic [2:0]  cc,
  output logic        busy
);

  state_e      r_state;
  logic        r_fav1;
  logic        r_owner;
  logic [1:0]  r_op;
  logic [63:0] r_a;
  logic [63:0] r_b;
  logic        r_valid;
  logic        r_res_id;
  logic [63:0] r_result;
  logic [2:0]  r_cc;

  logic        w_idle;
  logic        w_pick1;
  logic [63:0] w_alu_res;
  logic        w_zf;
  logic        w_sf;
  logic        w_of;

  alu_core u_alu (
    .op     (r_op),
    .a      (r_a),
    .b      (r_b),
    .result (w_alu_res),
    .zf     (w_zf),
    .sf     (w_sf),
    .of     (w_of)
  );

  // Grants are decoded from the registered state so they can only appear in IDLE
  // and the requester sees its accept in the same cycle it is latched.
  assign w_idle  = (r_state == ST_IDLE) && !rst;
  assign w_pick1 = req1 && (!req0 || r_fav1);
  assign gnt0    = w_idle && req0 && !w_pick1;
  assign gnt1    = w_idle && w_pick1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_fav1   <= 1'b0;
      r_owner  <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_valid  <= 1'b0;
      r_res_id <= 1'b0;
      r_result <= '0;
      r_cc     <= CC_RESET;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (gnt0 || gnt1) begin
            r_op    <= w_pick1 ? op1 : op0;
            r_a     <= w_pick1 ? a1  : a0;
            r_b     <= w_pick1 ? b1  : b0;
            r_owner <= w_pick1;
            r_fav1  <= !w_pick1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_result     <= w_alu_res;
          r_cc[CC_ZF]  <= w_zf;
          r_cc[CC_SF]  <= w_sf;
          r_cc[CC_OF]  <= w_of;
          r_res_id     <= r_owner;
          r_valid      <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign valid  = r_valid;
  assign res_id = r_res_id;
  assign result = r_result;
  assign cc     = r_cc;
  assign busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed corner cases plus random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [1:0]  op0, op1;
  logic [63:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, valid, res_id, busy;
  logic [63:0] result;
  logic [2:0]  cc;

  int unsigned total = 0;
  int unsigned bad   = 0;

  alu_share_ctrl dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .valid(valid), .res_id(res_id),
    .result(result), .cc(cc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference ALU: exact signed arithmetic in 65 bits, overflow = not representable in 64.
  function automatic logic [66:0] ref_alu(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    logic signed [64:0] sa, sb, s;
    logic [63:0] r;
    logic        ovf;
    sa = $signed({a[63], a});
    sb = $signed({b[63], b});
    ovf = 1'b0;
    case (op)
      2'd0: begin s = sa + sb; r = s[63:0]; ovf = (s[64] != s[63]); end
      2'd1: begin s = sa - sb; r = s[63:0]; ovf = (s[64] != s[63]); end
      2'd2: r = a & b;
      default: r = a ^ b;
    endcase
    return {(r == 64'd0), r[63], ovf, r};
  endfunction

  typedef struct {
    int          due;
    logic [63:0] r;
    logic [2:0]  c;
    logic        id;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          m_idle_at = 0;
  logic        m_fav1 = 1'b0;
  logic [63:0] m_res = '0;
  logic [2:0]  m_cc = 3'b100;
  logic        m_id = 1'b0;
  logic        s_gnt0 = 1'b0, s_gnt1 = 1'b0;
  int          g0_cyc = 0, g1_cyc = 0;

  always @(negedge clk) begin
    logic        ev, ebusy, w;
    logic [66:0] ra;
    exp_t        e;
    cyc++;
    ev = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev = 1'b1;
      m_res = q[0].r; m_cc = q[0].c; m_id = q[0].id;
      void'(q.pop_front());
    end
    chk("valid", valid, ev);
    chk("result", result, m_res);
    chk("cc", cc, m_cc);
    chk("res_id", res_id, m_id);
    ebusy = (cyc < m_idle_at);
    chk("busy", busy, ebusy);
    w = 1'b0;
    if (!rst && !ebusy && (req0 || req1)) begin
      w = (req0 && req1) ? m_fav1 : req1;
      ra = w ? ref_alu(op1, a1, b1) : ref_alu(op0, a0, b0);
      e.due = cyc + 2; e.r = ra[63:0]; e.c = ra[66:64]; e.id = w;
      q.push_back(e);
      m_idle_at = cyc + 3;
      m_fav1 = !w;
      chk("gnt0", gnt0, !w);
      chk("gnt1", gnt1, w);
    end else begin
      chk("gnt0", gnt0, 0);
      chk("gnt1", gnt1, 0);
    end
    chk("gnt_excl", gnt0 & gnt1, 0);
    if (gnt0) g0_cyc = cyc;
    if (gnt1) g1_cyc = cyc;
    s_gnt0 = gnt0;
    s_gnt1 = gnt1;
    if (rst) begin
      q.delete();
      m_idle_at = cyc + 1;
      m_fav1 = 1'b0;
      m_res = '0; m_cc = 3'b100; m_id = 1'b0;
    end
  end

  logic dropped0, dropped1;

  task automatic step();
    @(posedge clk);
    #1;
    dropped0 = s_gnt0;
    dropped1 = s_gnt1;
    if (s_gnt0) req0 = 1'b0;
    if (s_gnt1) req1 = 1'b0;
  endtask

  task automatic req_set(input logic id, input logic [1:0] op, input logic [63:0] a, input logic [63:0] b);
    if (id) begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (valid) begin n = i; break; end
    end
    if (n == 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  function automatic logic [63:0] pick64();
    case ($urandom_range(0, 4))
      0: return 64'h7FFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'd0;
      3: return '1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    int n;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) step();
    chk("rst_result", result, 0);
    chk("rst_cc", cc, 3'b100);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // add 5+7
    req_set(0, 2'd0, 64'd5, 64'd7);
    wait_valid("d1", n);
    chk("d1_lat", n, 2);
    chk("d1_res", result, 64'd12);
    chk("d1_cc", cc, 3'b000);
    chk("d1_id", res_id, 0);

    // both requesting after reset: requester 0 first, then 1
    do_reset(1);
    req_set(0, 2'd1, 64'd3, 64'd3);
    req_set(1, 2'd3, 64'hF0, 64'h0F);
    wait_valid("d2a", n);
    chk("d2a_res", result, 0);
    chk("d2a_cc", cc, 3'b100);
    chk("d2a_id", res_id, 0);
    wait_valid("d2b", n);
    chk("d2b_res", result, 64'hFF);
    chk("d2b_cc", cc, 3'b000);
    chk("d2b_id", res_id, 1);

    // overflow corners
    step();
    req_set(0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    wait_valid("d3a", n);
    chk("d3a_res", result, 64'h8000_0000_0000_0000);
    chk("d3a_cc", cc, 3'b011);
    req_set(0, 2'd1, 64'h8000_0000_0000_0000, 64'd1);
    wait_valid("d3b", n);
    chk("d3b_res", result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("d3b_cc", cc, 3'b001);

    // req1 raised while requester 0 is in EXEC
    step();
    req_set(0, 2'd2, 64'hFF00, 64'h0FF0);
    step();
    req_set(1, 2'd0, 64'd100, 64'd1);
    wait_valid("d4a", n);
    chk("d4a_res", result, 64'h0F00);
    chk("d4a_id", res_id, 0);
    wait_valid("d4b", n);
    chk("d4b_res", result, 64'd101);
    chk("d4b_id", res_id, 1);
    chk("d4_gap", g1_cyc - g0_cyc, 3);

    // reset during EXEC with requester 1 holding
    step();
    req_set(0, 2'd0, 64'd1, 64'd1);
    step();
    rst = 1'b1;
    req_set(1, 2'd1, 64'd10, 64'd4);
    step();
    rst = 1'b0;
    #1;
    chk("d5_valid", valid, 0);
    chk("d5_busy", busy, 0);
    chk("d5_result", result, 0);
    chk("d5_cc", cc, 3'b100);
    chk("d5_gnt1", gnt1, 1);
    wait_valid("d5", n);
    chk("d5_res", result, 64'd6);
    chk("d5_id", res_id, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step();
      rst = ($urandom_range(0, 49) == 0);
      if (!req0 && !dropped0 && $urandom_range(0, 2) == 0)
        req_set(0, 2'($urandom_range(0, 3)), pick64(), pick64());
      if (!req1 && !dropped1 && $urandom_range(0, 2) == 0)
        req_set(1, 2'($urandom_range(0, 3)), pick64(), pick64());
    end
    rst = 1'b0;
    repeat (6) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
